// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of a Johnson counter bus: FSM encoding,
// default width and the phase-index width helper.
package johnson_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int ph_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code checker/decoder: flags legal codes and maps them
// to a binary phase index 0..2N-1.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  localparam int PH_W  = ph_w(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic             legal,
  output logic [PH_W-1:0]  phase
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] qn;
  logic             lsb_run;
  logic             msb_run;
  int               ones;

  always_comb begin
    qn      = ~q;
    // A run of ones anchored at the LSB is 2^k-1; at the MSB its complement is.
    lsb_run = ((q & (q + ONE)) == '0);
    msb_run = ((qn & (qn + ONE)) == '0);
    legal   = lsb_run | msb_run;
    ones    = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(q[i]);
    end
    if (q[0] || (q == '0)) begin
      phase = PH_W'(ones);
    end else begin
      phase = PH_W'(2 * WIDTH - ones);
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter monitor: validates codes and steps, decodes a trusted phase,
// tracks lock, counts revolutions and keeps sticky error flags.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  LOCK_CNT = 2,
  parameter int  REV_W    = 8,
  localparam int PH_W     = ph_w(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   q,
  input  logic               err_clr,
  output logic [PH_W-1:0]    phase,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic               phase_valid,
  output logic               locked,
  output logic               rev_tick,
  output logic [REV_W-1:0]   rev_count,
  output logic               err_code,
  output logic               err_step
);

  localparam int                NPH     = 2 * WIDTH;
  localparam int                CNT_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [PH_W-1:0]   LAST_PH = PH_W'(NPH - 1);
  localparam logic [NPH-1:0]    OH_ONE  = NPH'(1);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(LOCK_CNT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PH_W-1:0]  prev_phase;
  logic             prev_valid;

  logic             legal_p0;
  logic [PH_W-1:0]  dph_p0;
  logic [PH_W-1:0]  adv_ph;
  logic             is_hold, is_adv, bad_step;
  logic             set_code, set_step, tick;

  // Stage p0: combinational decode of the incoming code
  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .q     (q),
    .legal (legal_p0),
    .phase (dph_p0)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_step  = 1'b0;
    tick      = 1'b0;
    adv_ph    = (prev_phase == LAST_PH) ? '0 : prev_phase + 1'b1;
    is_hold   = prev_valid && legal_p0 && (dph_p0 == prev_phase);
    is_adv    = prev_valid && legal_p0 && (dph_p0 == adv_ph);
    bad_step  = prev_valid && legal_p0 && !is_hold && !is_adv;
    set_code  = !legal_p0;
    case (state)
      SYNC: begin
        if (!legal_p0 || bad_step) begin
          cnt_nxt = '0;
        end else if (is_adv) begin
          if (cnt == CNT_TOP) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      TRACK: begin
        if (!legal_p0 || bad_step) begin
          state_nxt = SYNC;
          cnt_nxt   = '0;
          set_step  = bad_step;
        end else if (is_adv && (prev_phase == LAST_PH)) begin
          tick = 1'b1;
        end
      end
    endcase
  end

  // Stage p1: registered FSM and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SYNC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      prev_phase   <= '0;
      prev_valid   <= 1'b0;
      rev_tick     <= 1'b0;
      rev_count    <= '0;
      err_code     <= 1'b0;
      err_step     <= 1'b0;
    end else begin
      rev_tick <= tick;
      if (tick) begin
        rev_count <= rev_count + 1'b1;
      end
      if (legal_p0) begin
        phase        <= dph_p0;
        phase_onehot <= OH_ONE << dph_p0;
        phase_valid  <= 1'b1;
        prev_phase   <= dph_p0;
        prev_valid   <= 1'b1;
      end else begin
        phase_onehot <= '0;
        phase_valid  <= 1'b0;
        prev_valid   <= 1'b0;
      end
      // A new error in the clearing cycle wins over err_clr.
      err_code <= set_code | (err_code & ~err_clr);
      err_step <= set_step | (err_step & ~err_clr);
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (WIDTH=4, LOCK_CNT=2) with a
// queue-based scoreboard fed by the stimulus and drained by a monitor.
module tb_johnson_phase_monitor;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 2;
  localparam int REV_W    = 8;
  localparam int PH_W     = 3;
  localparam int NPH      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] q = '0;
  logic             err_clr = 1'b0;
  logic [PH_W-1:0]  phase;
  logic [NPH-1:0]   phase_onehot;
  logic             phase_valid;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_code;
  logic             err_step;

  johnson_phase_monitor #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .REV_W    (REV_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .q            (q),
    .err_clr      (err_clr),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .rev_tick     (rev_tick),
    .rev_count    (rev_count),
    .err_code     (err_code),
    .err_step     (err_step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       id;
    logic [PH_W-1:0]  ph;
    logic [NPH-1:0]   oh;
    logic             vld;
    logic             lk;
    logic             tk;
    logic [REV_W-1:0] rc;
    logic             ec;
    logic             es;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s.phase", tag), 32'(phase), 0);
    check($sformatf("%s.onehot", tag), 32'(phase_onehot), 0);
    check($sformatf("%s.valid", tag), 32'(phase_valid), 0);
    check($sformatf("%s.locked", tag), 32'(locked), 0);
    check($sformatf("%s.tick", tag), 32'(rev_tick), 0);
    check($sformatf("%s.revcnt", tag), 32'(rev_count), 0);
    check($sformatf("%s.errcode", tag), 32'(err_code), 0);
    check($sformatf("%s.errstep", tag), 32'(err_step), 0);
  endtask

  // Monitor: outputs after each edge correspond to the oldest queued vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d.phase", e.id), 32'(phase), 32'(e.ph));
      check($sformatf("v%0d.onehot", e.id), 32'(phase_onehot), 32'(e.oh));
      check($sformatf("v%0d.valid", e.id), 32'(phase_valid), 32'(e.vld));
      check($sformatf("v%0d.locked", e.id), 32'(locked), 32'(e.lk));
      check($sformatf("v%0d.tick", e.id), 32'(rev_tick), 32'(e.tk));
      check($sformatf("v%0d.revcnt", e.id), 32'(rev_count), 32'(e.rc));
      check($sformatf("v%0d.errcode", e.id), 32'(err_code), 32'(e.ec));
      check($sformatf("v%0d.errstep", e.id), 32'(err_step), 32'(e.es));
    end
  end

  // Drive one vector at a falling edge and queue its hand-computed response.
  task automatic step(input logic [3:0] qq, input logic clr, input int ph, input logic vld,
                      input logic lk, input logic tk, input int rc, input logic ec, input logic es);
    exp_t e;
    vec_id++;
    q        = qq;
    err_clr  = clr;
    e.id     = 8'(vec_id);
    e.ph     = PH_W'(ph);
    e.oh     = vld ? (NPH'(1) << ph) : '0;
    e.vld    = vld;
    e.lk     = lk;
    e.tk     = tk;
    e.rc     = REV_W'(rc);
    e.ec     = ec;
    e.es     = es;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    //    q       clr ph vld lk tk rc ec es
    // acquire lock
    step(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
    step(4'b0001, 0, 1, 1, 0, 0, 0, 0, 0);
    step(4'b0011, 0, 2, 1, 1, 0, 0, 0, 0);
    // one full revolution while locked
    step(4'b0111, 0, 3, 1, 1, 0, 0, 0, 0);
    step(4'b1111, 0, 4, 1, 1, 0, 0, 0, 0);
    step(4'b1110, 0, 5, 1, 1, 0, 0, 0, 0);
    step(4'b1100, 0, 6, 1, 1, 0, 0, 0, 0);
    step(4'b1000, 0, 7, 1, 1, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 1, 1, 1, 1, 0, 0);
    step(4'b0001, 0, 1, 1, 1, 0, 1, 0, 0);
    // illegal code loses lock, then relock
    step(4'b0101, 0, 1, 0, 0, 0, 1, 1, 0);
    step(4'b0001, 0, 1, 1, 0, 0, 1, 1, 0);
    step(4'b0011, 0, 2, 1, 0, 0, 1, 1, 0);
    step(4'b0111, 0, 3, 1, 1, 0, 1, 1, 0);
    // hold for five cycles while locked
    for (int i = 0; i < 5; i++) step(4'b0111, 0, 3, 1, 1, 0, 1, 1, 0);
    // second revolution then a skipped code
    step(4'b1111, 0, 4, 1, 1, 0, 1, 1, 0);
    step(4'b1110, 0, 5, 1, 1, 0, 1, 1, 0);
    step(4'b1100, 0, 6, 1, 1, 0, 1, 1, 0);
    step(4'b1000, 0, 7, 1, 1, 0, 1, 1, 0);
    step(4'b0000, 0, 0, 1, 1, 1, 2, 1, 0);
    step(4'b0001, 0, 1, 1, 1, 0, 2, 1, 0);
    step(4'b0011, 0, 2, 1, 1, 0, 2, 1, 0);
    step(4'b1111, 0, 4, 1, 0, 0, 2, 1, 1);
    // clear racing a new illegal code, then a clean clear
    step(4'b0110, 1, 4, 0, 0, 0, 2, 1, 0);
    step(4'b0000, 1, 0, 1, 0, 0, 2, 0, 0);
    step(4'b0000, 0, 0, 1, 0, 0, 2, 0, 0);
    // illegal step in SYNC leaves err_step clear
    step(4'b0011, 0, 2, 1, 0, 0, 2, 0, 0);
    step(4'b0111, 0, 3, 1, 0, 0, 2, 0, 0);
    step(4'b1111, 0, 4, 1, 1, 0, 2, 0, 0);
    step(4'b1110, 0, 5, 1, 1, 0, 2, 0, 0);
    step(4'b1100, 0, 6, 1, 1, 0, 2, 0, 0);
    step(4'b1000, 0, 7, 1, 1, 0, 2, 0, 0);
    step(4'b0000, 0, 0, 1, 1, 1, 3, 0, 0);
    step(4'b0000, 0, 0, 1, 1, 0, 3, 0, 0);
    // asynchronous reset in TRACK, away from any clock edge
    reset   = 1'b0;
    err_clr = 1'b0;
    #1;
    check("drain_a", 32'(sb.size()), 0);
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    step(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
    step(4'b0001, 0, 1, 1, 0, 0, 0, 0, 0);
    check("drain_b", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the johnson_counter output bus `q`.
- Each cycle it samples the Johnson code, checks that the code is legal and that the step from the previous code is legal, and decodes the code to a binary phase index and a one-hot phase.
- It also acquires and loses lock, counts full revolutions, and raises sticky error flags.
- Sits between the counter and the phase-sequenced logic that needs a trusted phase.

Parameters:
- WIDTH, 4, Johnson counter width N; 2N legal codes.
- LOCK_CNT, 2, consecutive legal advances required to enter TRACK.
- REV_W, 8, width of the revolution counter.
- PH_W (localparam), clog2(2*WIDTH), width of the phase index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- q  in  WIDTH  Johnson code from the upstream counter.
- err_clr  in  1  synchronous clear of the sticky error flags.
- phase  out  PH_W  decoded phase index, 0..2N-1.
- phase_onehot  out  2*WIDTH  one-hot of phase; all zeros when phase_valid=0.
- phase_valid  out  1  the last sampled code was legal.
- locked  out  1  high while in the TRACK state.
- rev_tick  out  1  one-cycle pulse on a 2N-1 -> 0 advance while locked.
- rev_count  out  REV_W  number of revolutions while locked; wraps modulo 2^REV_W.
- err_code  out  1  sticky: an illegal code was sampled.
- err_step  out  1  sticky: a legal code arrived via an illegal step while locked.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs are 0; state=SYNC; the lock counter is 0.
  - internal prev_phase=0; prev_valid=0.
- Latency: all outputs are registered. Values visible after edge t reflect the `q` sampled at edge t.
- Legal code: `q` is a contiguous run of ones anchored at the LSB, or at the MSB, or `q` is all zeros.
  - For WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Phase decode:
  - if q[0]=1 or q=0: phase = popcount(q).
  - otherwise: phase = 2N - popcount(q).
  - Example: 1110 -> 5; 1000 -> 7.
- Legal step: the new phase equals prev_phase (hold), or equals (prev_phase+1) mod 2N (advance). Only checked when prev_valid=1.
- Illegal code:
  - phase holds its last value; phase_valid=0; phase_onehot=0.
  - err_code<=1; prev_valid<=0.
- Legal code: phase, phase_onehot and prev_phase update; phase_valid=1; prev_valid<=1.
- FSM SYNC:
  - A legal advance with prev_valid=1 increments the lock counter.
  - A hold leaves the counter unchanged.
  - An illegal code or illegal step clears the counter. In SYNC this does not set err_step.
  - When the counter reaches LOCK_CNT: go to TRACK; locked=1 on the same edge; counter cleared.
- FSM TRACK:
  - An illegal code sets err_code; an illegal step sets err_step.
  - Either event sends the FSM to SYNC: locked=0 on that edge, counter cleared.
  - An advance 2N-1 -> 0 pulses rev_tick for one cycle and increments rev_count. A hold at phase 0 does not pulse rev_tick.
- rev_count is held through loss of lock. It is cleared only by reset.
- err_clr clears both sticky flags on the next edge.
  - If a new error condition occurs in the same cycle, the set wins and that flag stays 1.
- Reset asserted mid-TRACK: outputs go to 0 immediately, without waiting for a clock edge.
- After reset deassertion: a legal 0000 input is accepted as the first code (prev_valid becomes 1).

Decomposition:
- Shared package johnson_pkg:
  - FSM state encoding: SYNC=1'b0, TRACK=1'b1.
  - Phase-width helper function.
  - Default WIDTH constant.
- One natural sub-module, johnson_decode (purely combinational):
  - input: `q`.
  - outputs: `legal` and `phase`.
  - Reused by other Johnson consumers.

Test Plan (WIDTH=4, LOCK_CNT=2):
1. Reset, then drive 0000, 0001, 0011 on consecutive edges -> locked=1 after the edge sampling 0011; phase=2; phase_onehot=00000100; no errors.
2. While locked, advance through 0111, 1111, 1110, 1100, 1000, 0000 -> rev_tick high for exactly the one cycle after 0000 is sampled; rev_count=1.
3. While locked, inject 0101 -> next cycle err_code=1, locked=0, phase_valid=0, phase_onehot=0, phase held. Then drive 0001, 0011, 0111 -> locked=1 again.
4. While locked, step 0011 -> 1111 (skips 0111) -> err_step=1; locked=0; phase=4; phase_valid=1.
5. While locked, hold 0111 for 5 cycles -> locked stays 1, phase=3, no rev_tick, no errors.
6. With err_code=1:
   - assert err_clr together with an illegal code -> err_code stays 1.
   - err_clr alone -> err_code=0.
   - assert reset mid-TRACK -> all outputs 0 before the next clk edge.
